// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the register-file write port between ALU and LSU
//            writebacks and tracks pending writes for issue hazard stalls.
//            Optional forwarding of the in-flight write: define WB_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic        iss_use_rs1,
  input  logic        iss_use_rs2,
  output logic        iss_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
`ifdef WB_FWD_EN
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_data,
`endif
  output logic        sb_err
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [31:0] r_pending;
  logic [3:0]  r_starve_cnt;

  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_shadow1;
  logic        w_shadow2;
  logic        w_force_alu;
  logic        w_grant;
  logic [4:0]  w_gnt_rd;
  logic [31:0] w_gnt_data;
  logic        w_wb_write;
  logic        w_issue_set;
  logic [31:0] w_pending_nxt;

  always_comb begin
    w_raw1 = iss_use_rs1 && (iss_rs1 != 5'd0) && r_pending[iss_rs1];
    w_raw2 = iss_use_rs2 && (iss_rs2 != 5'd0) && r_pending[iss_rs2];
    w_waw  = (iss_rd != 5'd0) && r_pending[iss_rd];
`ifdef WB_FWD_EN
    w_shadow1 = 1'b0;
    w_shadow2 = 1'b0;
`else
    // The register file is written at the end of the rf_we cycle, so a reader
    // in that same cycle would still see the stale value.
    w_shadow1 = iss_use_rs1 && (iss_rs1 != 5'd0) && rf_we && (iss_rs1 == rf_waddr);
    w_shadow2 = iss_use_rs2 && (iss_rs2 != 5'd0) && rf_we && (iss_rs2 == rf_waddr);
`endif
    iss_stall = iss_valid && (w_raw1 || w_raw2 || w_waw || w_shadow1 || w_shadow2);
  end

  always_comb begin
    w_force_alu = alu_valid && (r_starve_cnt == C_STARVE_MAX);
    alu_ready   = alu_valid && (w_force_alu || !lsu_valid);
    lsu_ready   = lsu_valid && !w_force_alu;
    w_grant     = alu_ready || lsu_ready;
    w_gnt_rd    = alu_ready ? alu_rd   : lsu_rd;
    w_gnt_data  = alu_ready ? alu_data : lsu_data;
    w_wb_write  = w_grant && (w_gnt_rd != 5'd0);
    w_issue_set = iss_valid && !iss_stall && (iss_rd != 5'd0);
  end

  // WAW stalling guarantees set and clear never hit the same register.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_write) begin
      w_pending_nxt[w_gnt_rd] = 1'b0;
    end
    if (w_issue_set) begin
      w_pending_nxt[iss_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending    <= 32'd0;
      r_starve_cnt <= 4'd0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'd0;
      rf_wdata     <= 32'd0;
      sb_err       <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (alu_ready) begin
        r_starve_cnt <= 4'd0;
      end else if (alu_valid && (r_starve_cnt != C_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      rf_we <= w_wb_write;
      if (w_wb_write) begin
        rf_waddr <= w_gnt_rd;
        rf_wdata <= w_gnt_data;
      end
      if (w_wb_write && !r_pending[w_gnt_rd]) begin
        sb_err <= 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_rs1_hit = rf_we && (iss_rs1 == rf_waddr) && (iss_rs1 != 5'd0);
  assign fwd_rs2_hit = rf_we && (iss_rs2 == rf_waddr) && (iss_rs2 != 5'd0);
  assign fwd_data    = rf_wdata;
`endif

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

- Sits between the execution units and the 32×32 register file.
- Shares the register file's single write port between two writeback sources: the ALU and the load/store unit (LSU).
- Holds a 32-entry pending-write scoreboard. The issue stage uses it to stall on RAW and WAW hazards.
- Registers the port outputs (rf_we/rf_waddr/rf_wdata) that drive the register file's regwrite/waddr/wdata inputs.

## Interface
- STARVE_MAX, default 4: consecutive denied ALU cycles before the ALU is forced to win arbitration (range 1–15).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  an instruction is attempting issue this cycle.
- iss_rd  in  5  destination register of the issuing instruction.
- iss_rs1, iss_rs2  in  5  source registers.
- iss_use_rs1, iss_use_rs2  in  1  the corresponding source is actually read.
- iss_stall  out  1  hazard detected; the issue is not accepted this cycle.
- alu_valid, alu_rd, alu_data  in  1/5/32  ALU writeback request.
- alu_ready  out  1  ALU request granted this cycle.
- lsu_valid, lsu_rd, lsu_data  in  1/5/32  LSU load-return writeback request.
- lsu_ready  out  1  LSU request granted this cycle.
- rf_we, rf_waddr, rf_wdata  out  1/5/32  registered register-file write port.
- sb_err  out  1  sticky flag: a writeback targeted a non-pending register.

## Operation
**Scoreboard (pending[31:1], 1 bit per register; x0 is never tracked)**
- Set: iss_valid && !iss_stall && iss_rd != 0 sets pending[iss_rd] at the clock edge.
- Clear: a granted writeback with rd != 0 clears pending[rd] at the clock edge.

**Stall rule.** iss_stall = iss_valid && (RAW1 || RAW2 || WAW).
- RAW1 = iss_use_rs1 && rs1 != 0 && pending[rs1].
- RAW2 is the same check for rs2.
- WAW = iss_rd != 0 && pending[iss_rd].
- Because WAW stalls, a set and a clear of the same register in one cycle cannot occur. A set and a clear of different registers in the same cycle both take effect.

**Arbitration**
- Default priority is LSU over ALU; only one grant per cycle.
- starve_cnt (4 bits):
  - increments each cycle alu_valid && !alu_ready, saturating at STARVE_MAX;
  - resets to 0 on an ALU grant.
- When starve_cnt == STARVE_MAX and alu_valid, the ALU wins over the LSU.
- The ready outputs are combinational from the valid inputs and starve_cnt.
- A requester holds valid, rd and data stable until it sees ready.

**Writeback**
- On a grant with rd != 0: the next cycle shows rf_we=1, rf_waddr=rd, rf_wdata=data.
- Otherwise rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- A grant to rd=0 is still acked but produces no write.
- sb_err is set if a granted rd != 0 has pending[rd]=0. It clears only on reset.

## Timing
**Reset values.** Asserting resetn low, including mid-operation, clears immediately:
- pending to 0 and starve_cnt to 0;
- rf_we, rf_waddr and rf_wdata to 0;
- sb_err to 0.

iss_stall, alu_ready and lsu_ready then follow the inputs combinationally.

**Write timeline**
- Grant in cycle N.
- rf_we high in cycle N+1; the register file updates at the end of N+1.
- Data is readable from the register file in N+2.

**Scoreboard clear vs. dependent issue**
- The pending bit clears at the end of N.
- Without forwarding, the RAW stall is extended through N+1 by a one-cycle shadow: a source equal to rf_waddr while rf_we=1 also stalls.
- A dependent instruction therefore issues in N+2 at the earliest.

**Throughput.** One write per cycle. Back-to-back grants are allowed with no bubble.

## Configuration
Macro WB_FWD_EN, with it defined:
- Adds outputs fwd_rs1_hit (1), fwd_rs2_hit (1) and fwd_data (32).
- fwd_rsX_hit = rf_we && rsX == rf_waddr && rsX != 0; fwd_data = rf_wdata.
- The shadow stall is removed, so a dependent instruction issues in N+1 using the forwarded value.

Without it: no forwarding ports, and the shadow stall applies.

## Test plan
- **Reset:** reset mid-stream with pending[5]=1 and starve_cnt=3 → all outputs 0, pending empty, and an issue reading x5 is not stalled.
- **RAW:** issue rd=x5, then an issue reading rs1=x5 stalls until the ALU writes x5=0xDEADBEEF.
  - Without WB_FWD_EN: the dependent instruction issues 2 cycles after the grant.
  - With WB_FWD_EN: it issues 1 cycle after the grant, with fwd_rs1_hit=1 and fwd_data=0xDEADBEEF.
- **Collision:** ALU and LSU both valid (rd=x3, x4) → LSU granted first, ALU next cycle; rf_waddr shows 4 then 3 on consecutive cycles.
- **Starvation:** LSU held valid continuously with STARVE_MAX=4 → ALU granted on its 5th requesting cycle, and starve_cnt then returns to 0.
- **x0:** ALU writeback to x0 → alu_ready=1, rf_we stays 0; an issue with rd=x0 never stalls.
- **Error and WAW:** a writeback to a non-pending x7 sets sb_err until reset; an issue with rd=x9 while pending[9]=1 asserts iss_stall.
